// File: rtl/logic_gate_bank.sv
// logic_gate_bank: registered bitwise logic unit with a result FIFO.
// Each accepted beat computes Y = f(OP, A, B) over WIDTH bits, plus Z = (Y == 0).
// The result is queued in a DEPTH-entry FIFO and delivered to a consumer that may stall.
// Optional feature macro: GATE_ERR_EN. When defined, it adds the ERR port and a
// per-entry err bit that flags results produced by the reserved OP = 7.
//
// Handshake: a beat moves on a rising edge exactly when valid && ready on that side.
// IN_READY and OUT_VALID are decoded only from the registered occupancy count.
// There is no path from OUT_READY to IN_READY, so a full FIFO refuses input
// even in a cycle where the head is being popped.
// Once OUT_VALID is high, Y/Z/ERR hold until the head is popped.
module logic_gate_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OP,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Y,
    output logic             Z,
    output logic [CNT_W-1:0] CNT
`ifdef GATE_ERR_EN
    ,
    output logic             ERR
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] y_mem [DEPTH];
    logic             z_mem [DEPTH];
`ifdef GATE_ERR_EN
    logic             err_mem [DEPTH];
    logic             res_err;
`endif

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [WIDTH-1:0] res;
    logic             push;
    logic             pop;

    assign IN_READY  = (count != FULL_CNT);
    assign OUT_VALID = (count != '0);
    assign push      = IN_VALID && IN_READY;
    assign pop       = OUT_VALID && OUT_READY;

    // Bitwise operation selected by OP for the beat being offered.
    always_comb begin
        res = '0;
`ifdef GATE_ERR_EN
        res_err = 1'b0;
`endif
        case (OP)
            3'd0:    res = A & B;
            3'd1:    res = A | B;
            3'd2:    res = ~(A & B);
            3'd3:    res = ~(A | B);
            3'd4:    res = A ^ B;
            3'd5:    res = ~(A ^ B);
            3'd6:    res = ~A;
            default: begin
`ifdef GATE_ERR_EN
                // Reserved op yields a zero result tagged as an error.
                res     = '0;
                res_err = 1'b1;
`else
                // Reserved op aliases NOR.
                res = ~(A | B);
`endif
            end
        endcase
    end

    // FIFO storage: cleared on reset, tail entry written on accept.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                y_mem[i] <= '0;
                z_mem[i] <= 1'b1;
`ifdef GATE_ERR_EN
                err_mem[i] <= 1'b0;
`endif
            end
        end else if (push) begin
            y_mem[wr_ptr] <= res;
            z_mem[wr_ptr] <= (res == '0);
`ifdef GATE_ERR_EN
            err_mem[wr_ptr] <= res_err;
`endif
        end
    end

    // Pointers and occupancy. A simultaneous push and pop leaves count unchanged.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Delivered-result counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) CNT <= '0;
        else if (pop) CNT <= CNT + CNT_W'(1);
    end

    // Head entry drives the outputs directly from storage.
    assign Y = y_mem[rd_ptr];
    assign Z = z_mem[rd_ptr];
`ifdef GATE_ERR_EN
    assign ERR = err_mem[rd_ptr];
`endif

endmodule

// File: tb/tb_logic_gate_bank.sv
// tb_logic_gate_bank: scoreboard bench for logic_gate_bank (WIDTH=8, DEPTH=2, CNT_W=4).
// Reference results come from per-op two-input truth tables applied bit by bit.
module tb_logic_gate_bank;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;

    logic             CLK = 1'b0;
    logic             RST;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       OP;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] Y;
    logic             Z;
    logic [CNT_W-1:0] CNT;
`ifdef GATE_ERR_EN
    logic             ERR;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;
    int cyc_cnt  = 0;
    bit rand_rdy = 1'b0;

    // Expected {err, z, y} per accepted beat, in acceptance order.
    logic [WIDTH+1:0] exp_q[$];
    // Y values as they were popped, for directed comparisons.
    logic [WIDTH-1:0] pop_log[$];

    logic [WIDTH-1:0] sweep_exp [7] = '{8'h88, 8'hEE, 8'h77, 8'h11, 8'h66, 8'h99, 8'h33};

    logic_gate_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK(CLK),
        .RST(RST),
        .IN_VALID(IN_VALID),
        .IN_READY(IN_READY),
        .A(A),
        .B(B),
        .OP(OP),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .Y(Y),
        .Z(Z),
        .CNT(CNT)
`ifdef GATE_ERR_EN
        ,
        .ERR(ERR)
`endif
    );

    // Clock and cycle counter.
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 4-entry truth table indexed by {a_bit, b_bit}.
    function automatic logic [WIDTH+1:0] model(input int op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [3:0]       tt;
        logic             err;
        logic [WIDTH-1:0] y;
        err = 1'b0;
        case (op)
            0: tt = 4'b1000;
            1: tt = 4'b1110;
            2: tt = 4'b0111;
            3: tt = 4'b0001;
            4: tt = 4'b0110;
            5: tt = 4'b1001;
            6: tt = 4'b0011;
            default: begin
`ifdef GATE_ERR_EN
                tt  = 4'b0000;
                err = 1'b1;
`else
                tt = 4'b0001;
`endif
            end
        endcase
        for (int i = 0; i < WIDTH; i++) y[i] = tt[{a[i], b[i]}];
        return {err, (y == '0), y};
    endfunction

    // Monitor: checks CNT every cycle and compares each popped head to the queue front.
    always @(negedge CLK) begin
        if (!RST) begin
            check("cnt", 64'(CNT), 64'(exp_cnt));
            if (OUT_VALID && OUT_READY) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", 64'(exp_q.size()), 64'd1);
                end else begin
                    logic [WIDTH+1:0] e;
                    e = exp_q.pop_front();
                    check("sb_y", 64'(Y), 64'(e[WIDTH-1:0]));
                    check("sb_z", 64'(Z), 64'(e[WIDTH]));
`ifdef GATE_ERR_EN
                    check("sb_err", 64'(ERR), 64'(e[WIDTH+1]));
`endif
                end
                pop_log.push_back(Y);
                exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
            end
        end
    end

    // Random consumer stall pattern, enabled only during the random phase.
    always @(posedge CLK) begin
        #2;
        if (rand_rdy) OUT_READY = 1'($urandom_range(0, 1));
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Driver: offer one beat and hold it until accepted (bounded).
    task automatic send(input int op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bit accepted;
        accepted = 1'b0;
        IN_VALID = 1'b1;
        OP = op[2:0];
        A = a;
        B = b;
        for (int t = 0; t < 50 && !accepted; t++) begin
            @(negedge CLK);
            if (IN_READY) begin
                exp_q.push_back(model(op, a, b));
                accepted = 1'b1;
            end
            cyc();
        end
        IN_VALID = 1'b0;
        check("send_accepted", 64'(accepted), 64'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) cyc();
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic reset_sync();
        RST = 1'b1;
        exp_q.delete();
        exp_cnt = 0;
        cyc();
        RST = 1'b0;
    endtask

    initial begin
        logic [WIDTH+1:0] first;
        logic [WIDTH-1:0] ra, rb;
        int start;

        RST = 1'b1;
        IN_VALID = 1'b0;
        A = '0;
        B = '0;
        OP = '0;
        OUT_READY = 1'b0;
        repeat (2) cyc();

        // Reset state.
        check("rst_out_valid", 64'(OUT_VALID), 64'd0);
        check("rst_in_ready", 64'(IN_READY), 64'd1);
        check("rst_cnt", 64'(CNT), 64'd0);
        check("rst_y", 64'(Y), 64'd0);
        check("rst_z", 64'(Z), 64'd1);
        RST = 1'b0;

        // Single NOR beat: 0F NOR F0 = 00.
        OUT_READY = 1'b1;
        send(3, 8'h0F, 8'hF0);
        @(negedge CLK);
        check("single_valid", 64'(OUT_VALID), 64'd1);
        check("single_y", 64'(Y), 64'h00);
        check("single_z", 64'(Z), 64'd1);
        cyc();
        @(negedge CLK);
        check("single_cnt", 64'(CNT), 64'd1);
        cyc();

        // Sweep OP 0..6 back to back, one result per cycle.
        pop_log.delete();
        start = cyc_cnt;
        for (int op = 0; op < 7; op++) send(op, 8'hCC, 8'hAA);
        check("sweep_cycles", 64'(cyc_cnt - start), 64'd7);
        drain();
        check("sweep_count", 64'(pop_log.size()), 64'd7);
        for (int i = 0; i < 7 && i < pop_log.size(); i++) check("sweep_y", 64'(pop_log[i]), 64'(sweep_exp[i]));

        // Fill with consumer stalled, then release.
        OUT_READY = 1'b0;
        ra = 8'($urandom);
        rb = 8'($urandom);
        first = model(0, ra, rb);
        send(0, ra, rb);
        send(1, 8'($urandom), 8'($urandom));
        @(negedge CLK);
        check("full_in_ready", 64'(IN_READY), 64'd0);
        check("full_out_valid", 64'(OUT_VALID), 64'd1);
        ra = 8'($urandom);
        rb = 8'($urandom);
        IN_VALID = 1'b1;
        OP = 3'd2;
        A = ra;
        B = rb;
        for (int k = 0; k < 2; k++) begin
            cyc();
            @(negedge CLK);
            check("full_hold_ready", 64'(IN_READY), 64'd0);
            check("full_hold_y", 64'(Y), 64'(first[WIDTH-1:0]));
        end
        cyc();
        OUT_READY = 1'b1;
        @(negedge CLK);
        check("no_bypass", 64'(IN_READY), 64'd0);
        cyc();
        @(negedge CLK);
        check("after_pop_ready", 64'(IN_READY), 64'd1);
        exp_q.push_back(model(2, ra, rb));
        cyc();
        IN_VALID = 1'b0;
        @(negedge CLK);
        check("pushpop_valid", 64'(OUT_VALID), 64'd1);
        check("pushpop_ready", 64'(IN_READY), 64'd1);
        cyc();
        drain();

        // Reserved op.
        pop_log.delete();
        send(7, 8'h00, 8'h00);
        drain();
`ifdef GATE_ERR_EN
        check("op7_y", 64'(pop_log.size() > 0 ? pop_log[0] : 8'hXX), 64'h00);
`else
        check("op7_y", 64'(pop_log.size() > 0 ? pop_log[0] : 8'hXX), 64'hFF);
`endif

        // Counter wrap: 17 deliveries from reset read back as 1.
        reset_sync();
        for (int i = 0; i < 17; i++) send(int'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        drain();
        @(negedge CLK);
        check("cnt_wrap", 64'(CNT), 64'd1);
        cyc();

        // Random traffic with a randomly stalling consumer.
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) cyc();
            send(int'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        end
        rand_rdy = 1'b0;
        OUT_READY = 1'b1;
        drain();

        // Asynchronous reset with two entries queued.
        OUT_READY = 1'b0;
        send(4, 8'($urandom), 8'($urandom));
        send(5, 8'($urandom), 8'($urandom));
        #2;
        RST = 1'b1;
        #1;
        check("arst_out_valid", 64'(OUT_VALID), 64'd0);
        check("arst_in_ready", 64'(IN_READY), 64'd1);
        check("arst_cnt", 64'(CNT), 64'd0);
        check("arst_y", 64'(Y), 64'd0);
        check("arst_z", 64'(Z), 64'd1);
        exp_q.delete();
        exp_cnt = 0;
        #2;
        RST = 1'b0;
        ra = 8'($urandom);
        rb = 8'($urandom);
        IN_VALID = 1'b1;
        OP = 3'd0;
        A = ra;
        B = rb;
        OUT_READY = 1'b1;
        exp_q.push_back(model(0, ra, rb));
        cyc();
        IN_VALID = 1'b0;
        @(negedge CLK);
        check("arst_first_valid", 64'(OUT_VALID), 64'd1);
        cyc();
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
